// File: rtl/dram_txn_scheduler_if.sv
// AR/AW pass-through handshakes plus the R/B handshakes the scheduler observes.
// "slave" is the scheduler's view; "master" is the surrounding fabric's view.
interface dram_txn_scheduler_if;
  logic slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
  logic slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
  logic r_valid_i, r_ready_i, r_last_i;
  logic b_valid_i, b_ready_i;

  modport slave (
    input  slv_ar_valid_i, mst_ar_ready_i, slv_aw_valid_i, mst_aw_ready_i,
    input  r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i,
    output slv_ar_ready_o, mst_ar_valid_o, slv_aw_ready_o, mst_aw_valid_o
  );

  modport master (
    output slv_ar_valid_i, mst_ar_ready_i, slv_aw_valid_i, mst_aw_ready_i,
    output r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i,
    input  slv_ar_ready_o, mst_ar_valid_o, slv_aw_ready_o, mst_aw_valid_o
  );
endinterface

// File: rtl/dram_txn_scheduler.sv
// DRAM address-channel scheduler: calibration gate, outstanding caps,
// direction batching with a quota, and a drain/quiesce handshake.
module dram_txn_scheduler #(
  parameter  int unsigned MaxReads  = 8,
  parameter  int unsigned MaxWrites = 8,
  parameter  int unsigned DirQuota  = 4,
  localparam int unsigned CntWidth  =
    $clog2(((MaxReads > MaxWrites) ? MaxReads : MaxWrites) + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     calib_done_i,
  input  logic                     drain_req_i,
  output logic                     drain_ack_o,
  dram_txn_scheduler_if.slave      bus,
  output logic [CntWidth-1:0]      rd_outstanding_o,
  output logic [CntWidth-1:0]      wr_outstanding_o
);
  localparam int unsigned StrkWidth = $clog2(DirQuota + 1);

  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DRAINED = 2'd3;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  logic [1:0]           r_state, w_state_nxt;
  logic [CntWidth-1:0]  r_rd_cnt, r_wr_cnt;
  logic                 r_dir;
  logic [StrkWidth-1:0] r_streak;
  logic                 r_lock, r_lock_dir, r_drain_ack;

  logic w_rd_ok, w_wr_ok, w_gnt_rd, w_gnt_wr;
  logic w_ar_hs, w_aw_hs, w_r_done, w_b_done;

  assign w_rd_ok = (r_state == S_RUN) && bus.slv_ar_valid_i && (32'(r_rd_cnt) < MaxReads);
  assign w_wr_ok = (r_state == S_RUN) && bus.slv_aw_valid_i && (32'(r_wr_cnt) < MaxWrites);

  // A locked direction always wins so a presented master valid never drops.
  always_comb begin
    w_gnt_rd = 1'b0;
    w_gnt_wr = 1'b0;
    if (rst_ni) begin
      if (r_lock) begin
        w_gnt_rd = (r_lock_dir == DIR_RD);
        w_gnt_wr = (r_lock_dir == DIR_WR);
      end else if (w_rd_ok && w_wr_ok) begin
        if (32'(r_streak) < DirQuota) w_gnt_rd = (r_dir == DIR_RD);
        else                          w_gnt_rd = (r_dir == DIR_WR);
        w_gnt_wr = !w_gnt_rd;
      end else begin
        w_gnt_rd = w_rd_ok;
        w_gnt_wr = w_wr_ok;
      end
    end
  end

  assign bus.mst_ar_valid_o = bus.slv_ar_valid_i & w_gnt_rd;
  assign bus.slv_ar_ready_o = bus.mst_ar_ready_i & w_gnt_rd;
  assign bus.mst_aw_valid_o = bus.slv_aw_valid_i & w_gnt_wr;
  assign bus.slv_aw_ready_o = bus.mst_aw_ready_i & w_gnt_wr;

  assign w_ar_hs  = w_gnt_rd & bus.slv_ar_valid_i & bus.mst_ar_ready_i;
  assign w_aw_hs  = w_gnt_wr & bus.slv_aw_valid_i & bus.mst_aw_ready_i;
  assign w_r_done = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;
  assign w_b_done = bus.b_valid_i & bus.b_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:    if (calib_done_i) w_state_nxt = S_RUN;
      S_RUN:     if (drain_req_i)  w_state_nxt = S_DRAIN;
      S_DRAIN:   if (!r_lock && (r_rd_cnt == '0) && (r_wr_cnt == '0)) w_state_nxt = S_DRAINED;
      S_DRAINED: if (!drain_req_i) w_state_nxt = S_RUN;
      default:   w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_INIT;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_dir       <= DIR_RD;
      r_streak    <= '0;
      r_lock      <= 1'b0;
      r_lock_dir  <= DIR_RD;
      r_drain_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_ack <= (w_state_nxt == S_DRAINED);

      if (w_ar_hs && !w_r_done)
        r_rd_cnt <= r_rd_cnt + CntWidth'(1);
      else if (!w_ar_hs && w_r_done && (r_rd_cnt != '0))
        r_rd_cnt <= r_rd_cnt - CntWidth'(1);

      if (w_aw_hs && !w_b_done)
        r_wr_cnt <= r_wr_cnt + CntWidth'(1);
      else if (!w_aw_hs && w_b_done && (r_wr_cnt != '0))
        r_wr_cnt <= r_wr_cnt - CntWidth'(1);

      if (w_ar_hs || w_aw_hs) begin
        r_lock <= 1'b0;
      end else if (w_gnt_rd && bus.slv_ar_valid_i) begin
        r_lock     <= 1'b1;
        r_lock_dir <= DIR_RD;
      end else if (w_gnt_wr && bus.slv_aw_valid_i) begin
        r_lock     <= 1'b1;
        r_lock_dir <= DIR_WR;
      end

      // Streak saturates at the quota; a handshake the other way restarts it.
      if (w_ar_hs) begin
        if (r_dir == DIR_RD) begin
          if (32'(r_streak) < DirQuota) r_streak <= r_streak + StrkWidth'(1);
        end else begin
          r_dir    <= DIR_RD;
          r_streak <= StrkWidth'(1);
        end
      end else if (w_aw_hs) begin
        if (r_dir == DIR_WR) begin
          if (32'(r_streak) < DirQuota) r_streak <= r_streak + StrkWidth'(1);
        end else begin
          r_dir    <= DIR_WR;
          r_streak <= StrkWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_r_done && (r_rd_cnt == '0))) else $error("read completion with no read outstanding");
      assert (!(w_b_done && (r_wr_cnt == '0))) else $error("write response with no write outstanding");
      assert (!(w_ar_hs && !w_r_done && (32'(r_rd_cnt) >= MaxReads))) else $error("read count overflow");
      assert (!(w_aw_hs && !w_b_done && (32'(r_wr_cnt) >= MaxWrites))) else $error("write count overflow");
    end
  end

  assign drain_ack_o      = r_drain_ack;
  assign rd_outstanding_o = r_rd_cnt;
  assign wr_outstanding_o = r_wr_cnt;
endmodule

// File: tb/tb_dram_txn_scheduler.sv
// Bench for dram_txn_scheduler: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_dram_txn_scheduler;
  localparam int MR = 8;
  localparam int MW = 8;
  localparam int Q  = 4;
  localparam int CW = $clog2(((MR > MW) ? MR : MW) + 1);

  logic          clk;
  logic          rst_ni;
  logic          calib_done;
  logic          drain_req;
  logic          drain_ack;
  logic [CW-1:0] rd_out, wr_out;

  dram_txn_scheduler_if bus ();

  dram_txn_scheduler #(.MaxReads(MR), .MaxWrites(MW), .DirQuota(Q)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .calib_done_i    (calib_done),
    .drain_req_i     (drain_req),
    .drain_ack_o     (drain_ack),
    .bus             (bus),
    .rd_outstanding_o(rd_out),
    .wr_outstanding_o(wr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit c, input bit arv, input bit awv, input bit arr, input bit awr);
    calib_done         = c;
    bus.slv_ar_valid_i = arv;
    bus.slv_aw_valid_i = awv;
    bus.mst_ar_ready_i = arr;
    bus.mst_aw_ready_i = awr;
  endtask

  task automatic set_rb(input bit rv, input bit rr, input bit rl, input bit bv, input bit br);
    bus.r_valid_i = rv;
    bus.r_ready_i = rr;
    bus.r_last_i  = rl;
    bus.b_valid_i = bv;
    bus.b_ready_i = br;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    drain_req = 1'b0;
    drv(0, 0, 0, 0, 0);
    set_rb(0, 0, 0, 0, 0);
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  typedef struct {
    bit       calib, arv, awv, arr, awr;
    bit [3:0] exp;   // {mst_ar_valid, slv_ar_ready, mst_aw_valid, slv_aw_ready}
  } vec_t;

  function automatic vec_t mk(bit c, bit a, bit w, bit ar, bit aw, bit [3:0] e);
    vec_t v;
    v.calib = c; v.arv = a; v.awv = w; v.arr = ar; v.awr = aw; v.exp = e;
    return v;
  endfunction

  // Reference model: outstanding bursts as queues, handshake direction history.
  int rd_q[$];
  int wr_q[$];
  bit hist[$];
  int m_mode;      // 0 init, 1 run, 2 drain, 3 drained
  bit m_pend, m_pend_wr;

  function automatic bit last_dir();
    return (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
  endfunction

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic void model_reset();
    rd_q.delete();
    wr_q.delete();
    hist.delete();
    m_mode    = 0;
    m_pend    = 0;
    m_pend_wr = 0;
  endfunction

  vec_t tbl [16];
  bit   r_arv, r_awv, r_arr, r_awr, r_rv, r_rr, r_rl, r_bv, r_br, r_rdone, r_bdone;
  bit   r_rst, r_drain, ar_hold, aw_hold, g_rd, g_wr, rok, wok, pick_wr, ar_hs, aw_hs;
  int   n_hs;

  initial begin
    tbl[0]  = mk(0, 1, 0, 1, 0, 4'b0000);
    tbl[1]  = mk(1, 1, 0, 1, 0, 4'b0000);
    tbl[2]  = mk(0, 1, 1, 1, 1, 4'b1100);
    tbl[3]  = mk(0, 1, 1, 1, 1, 4'b1100);
    tbl[4]  = mk(0, 1, 1, 1, 1, 4'b1100);
    tbl[5]  = mk(0, 1, 1, 1, 1, 4'b1100);
    tbl[6]  = mk(0, 1, 1, 1, 1, 4'b0011);
    tbl[7]  = mk(0, 1, 1, 1, 1, 4'b0011);
    tbl[8]  = mk(0, 1, 1, 1, 1, 4'b0011);
    tbl[9]  = mk(0, 1, 1, 1, 1, 4'b0011);
    tbl[10] = mk(0, 1, 1, 1, 1, 4'b1100);
    tbl[11] = mk(0, 0, 1, 1, 1, 4'b0011);
    tbl[12] = mk(0, 1, 0, 0, 1, 4'b1000);
    tbl[13] = mk(0, 1, 1, 0, 1, 4'b1000);
    tbl[14] = mk(0, 1, 1, 1, 1, 4'b1100);
    tbl[15] = mk(0, 1, 1, 1, 1, 4'b1100);

    // Reset state and vector table
    do_reset();
    @(negedge clk);
    chk("reset_ack", 32'(drain_ack), 0);
    chk("reset_rd", 32'(rd_out), 0);
    chk("reset_wr", 32'(wr_out), 0);
    for (int i = 0; i < 16; i++) begin
      drv(tbl[i].calib, tbl[i].arv, tbl[i].awv, tbl[i].arr, tbl[i].awr);
      @(negedge clk);
      chk($sformatf("tbl_row%0d", i),
          32'({bus.mst_ar_valid_o, bus.slv_ar_ready_o, bus.mst_aw_valid_o, bus.slv_aw_ready_o}),
          32'(tbl[i].exp));
      tick();
    end
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tbl_rd_cnt", 32'(rd_out), 7);
    chk("tbl_wr_cnt", 32'(wr_out), 5);

    // Calibration gate: calib rises in cycle 10
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      drv(c >= 10, 1, 0, 1, 0);
      @(negedge clk);
      chk($sformatf("calib_gate_c%0d", c), 32'(bus.mst_ar_valid_o), 32'(c >= 11));
      tick();
    end

    // Read cap
    do_reset();
    drv(1, 0, 0, 0, 0);
    tick();
    n_hs = 0;
    for (int c = 0; c < 12; c++) begin
      drv(0, 1, 0, 1, 0);
      @(negedge clk);
      n_hs += int'(bus.slv_ar_ready_o);
      tick();
    end
    chk("rdcap_handshakes", 32'(n_hs), 8);
    @(negedge clk);
    chk("rdcap_cnt", 32'(rd_out), 8);
    chk("rdcap_blocked", 32'(bus.slv_ar_ready_o), 0);
    set_rb(1, 1, 1, 0, 0);
    tick();
    set_rb(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rdcap_after_r_cnt", 32'(rd_out), 7);
    chk("rdcap_ninth_ready", 32'(bus.slv_ar_ready_o), 1);
    tick();
    @(negedge clk);
    chk("rdcap_refill_cnt", 32'(rd_out), 8);
    chk("rdcap_refill_blocked", 32'(bus.slv_ar_ready_o), 0);

    // Simultaneous AR handshake and R last at count 5
    do_reset();
    drv(1, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drv(0, 1, 0, 1, 0);
      tick();
    end
    @(negedge clk);
    chk("simul_pre_cnt", 32'(rd_out), 5);
    set_rb(1, 1, 1, 0, 0);
    @(negedge clk);
    chk("simul_hs", 32'(bus.slv_ar_ready_o), 1);
    tick();
    drv(0, 0, 0, 0, 0);
    set_rb(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("simul_cnt", 32'(rd_out), 5);

    // Lock stability: AR held unready for 5 cycles while AW is pending
    do_reset();
    drv(1, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drv(0, 1, c > 0, 0, 1);
      @(negedge clk);
      chk($sformatf("lock_ar_c%0d", c), 32'({bus.mst_ar_valid_o, bus.slv_ar_ready_o}), 32'(2'b10));
      chk($sformatf("lock_aw_c%0d", c), 32'(bus.mst_aw_valid_o), 0);
      tick();
    end
    drv(0, 1, 1, 1, 1);
    @(negedge clk);
    chk("lock_release", 32'({bus.slv_ar_ready_o, bus.mst_aw_valid_o}), 32'(2'b10));
    tick();
    drv(0, 0, 1, 0, 1);
    @(negedge clk);
    chk("lock_aw_next", 32'({bus.mst_aw_valid_o, bus.slv_aw_ready_o}), 32'(2'b11));
    tick();

    // Reset while locked
    drv(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("rstlock_pre", 32'(bus.mst_ar_valid_o), 1);
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    drv(0, 1, 0, 1, 0);
    @(negedge clk);
    chk("rstlock_valids", 32'({bus.mst_ar_valid_o, bus.slv_ar_ready_o, bus.mst_aw_valid_o, bus.slv_aw_ready_o}), 0);
    chk("rstlock_cnts", 32'({rd_out, wr_out}), 0);
    chk("rstlock_ack", 32'(drain_ack), 0);
    tick();
    @(negedge clk);
    chk("rstlock_init_hold", 32'(bus.mst_ar_valid_o), 0);

    // Drain with 3 reads and 2 writes outstanding
    do_reset();
    drv(1, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin drv(0, 1, 0, 1, 0); tick(); end
    for (int c = 0; c < 2; c++) begin drv(0, 0, 1, 0, 1); tick(); end
    drv(0, 0, 0, 0, 0);
    drain_req = 1'b1;
    @(negedge clk);
    chk("drain_pre_cnts", 32'({rd_out, wr_out}), 32'({4'(3), 4'(2)}));
    tick();
    for (int k = 0; k < 5; k++) begin
      drv(0, 1, 1, 1, 1);
      if (k < 3) set_rb(1, 1, 1, 0, 0);
      else       set_rb(0, 0, 0, 1, 1);
      @(negedge clk);
      chk($sformatf("drain_nogrant_k%0d", k), 32'({bus.mst_ar_valid_o, bus.mst_aw_valid_o}), 0);
      chk($sformatf("drain_noack_k%0d", k), 32'(drain_ack), 0);
      tick();
    end
    set_rb(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_zero_cnts", 32'({rd_out, wr_out}), 0);
    chk("drain_ack_notyet", 32'(drain_ack), 0);
    tick();
    drain_req = 1'b0;
    @(negedge clk);
    chk("drain_ack", 32'(drain_ack), 1);
    chk("drained_nogrant", 32'({bus.mst_ar_valid_o, bus.mst_aw_valid_o}), 0);
    tick();
    @(negedge clk);
    chk("resume_ack_low", 32'(drain_ack), 0);
    chk("resume_grant_wr", 32'({bus.mst_ar_valid_o, bus.mst_aw_valid_o}), 32'(2'b01));
    tick();

    // Randomized run against the reference model
    do_reset();
    model_reset();
    ar_hold = 0; aw_hold = 0; r_drain = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      r_arv = ar_hold | ($urandom_range(0, 2) != 0);
      r_awv = aw_hold | ($urandom_range(0, 2) != 0);
      r_arr = ($urandom_range(0, 2) != 0);
      r_awr = ($urandom_range(0, 2) != 0);
      r_rdone = (rd_q.size() > 0) && ($urandom_range(0, 2) == 0);
      r_bdone = (wr_q.size() > 0) && ($urandom_range(0, 2) == 0);
      if (r_rdone) begin r_rv = 1; r_rr = 1; r_rl = 1; end
      else begin
        r_rv = 1'($urandom_range(0, 1)); r_rr = 1'($urandom_range(0, 1)); r_rl = 1'($urandom_range(0, 1));
        if (r_rv && r_rr && r_rl) r_rl = 0;
      end
      if (r_bdone) begin r_bv = 1; r_br = 1; end
      else begin
        r_bv = 1'($urandom_range(0, 1)); r_br = 1'($urandom_range(0, 1));
        if (r_bv && r_br) r_br = 0;
      end
      if ($urandom_range(0, 39) == 0) r_drain = !r_drain;
      drain_req = r_drain;
      rst_ni    = !r_rst;
      drv((m_mode == 0) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)), r_arv, r_awv, r_arr, r_awr);
      set_rb(r_rv, r_rr, r_rl, r_bv, r_br);
      @(negedge clk);
      if (r_rst) begin
        chk("rnd_reset_outs", 32'({bus.mst_ar_valid_o, bus.slv_ar_ready_o, bus.mst_aw_valid_o, bus.slv_aw_ready_o}), 0);
        model_reset();
        ar_hold = 0; aw_hold = 0;
      end else begin
        g_rd = 0; g_wr = 0;
        if (m_pend) begin
          g_rd = !m_pend_wr; g_wr = m_pend_wr;
        end else if (m_mode == 1) begin
          rok = r_arv && (rd_q.size() < MR);
          wok = r_awv && (wr_q.size() < MW);
          if (rok && wok) begin
            pick_wr = (run_len() < Q) ? last_dir() : !last_dir();
            g_rd = !pick_wr; g_wr = pick_wr;
          end else begin
            g_rd = rok; g_wr = wok;
          end
        end
        chk("rnd_mst_ar_valid", 32'(bus.mst_ar_valid_o), 32'(r_arv & g_rd));
        chk("rnd_slv_ar_ready", 32'(bus.slv_ar_ready_o), 32'(r_arr & g_rd));
        chk("rnd_mst_aw_valid", 32'(bus.mst_aw_valid_o), 32'(r_awv & g_wr));
        chk("rnd_slv_aw_ready", 32'(bus.slv_aw_ready_o), 32'(r_awr & g_wr));
        chk("rnd_rd_cnt", 32'(rd_out), 32'(rd_q.size()));
        chk("rnd_wr_cnt", 32'(wr_out), 32'(wr_q.size()));
        chk("rnd_drain_ack", 32'(drain_ack), 32'(m_mode == 3));
        ar_hs = r_arv & g_rd & r_arr;
        aw_hs = r_awv & g_wr & r_awr;
        case (m_mode)
          0: if (calib_done) m_mode = 1;
          1: if (r_drain) m_mode = 2;
          2: if (!m_pend && rd_q.size() == 0 && wr_q.size() == 0) m_mode = 3;
          default: if (!r_drain) m_mode = 1;
        endcase
        m_pend    = (r_arv && g_rd && !r_arr) || (r_awv && g_wr && !r_awr);
        m_pend_wr = r_awv && g_wr && !r_awr;
        if (r_rdone) rd_q.delete(0);
        if (r_bdone) wr_q.delete(0);
        if (ar_hs) begin rd_q.push_back(cyc); hist.push_back(1'b0); end
        if (aw_hs) begin wr_q.push_back(cyc); hist.push_back(1'b1); end
        if (hist.size() > Q) hist.delete(0);
        ar_hold = r_arv && !ar_hs;
        aw_hold = r_awv && !aw_hs;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
